// File: rtl/regfile_context_engine.sv
// Save/restore sequencer driving the register file read/write ports.
// Streams a register range out on the save channel or reloads it from the restore channel.
module regfile_context_engine #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int FIRST_REG  = 0,
    parameter int LAST_REG   = 31
) (
    input  logic                  Clk,
    input  logic                  ResetN,
    input  logic                  SaveReq,
    input  logic                  RestoreReq,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH-1:0] RfReadAddr,
    input  logic [DATA_WIDTH-1:0] RfReadData,
    output logic [ADDR_WIDTH-1:0] RfWriteAddr,
    output logic [DATA_WIDTH-1:0] RfWriteData,
    output logic                  RfWriteEnable,
    output logic                  SaveValid,
    output logic [DATA_WIDTH-1:0] SaveData,
    output logic [ADDR_WIDTH-1:0] SaveIndex,
    input  logic                  SaveReady,
    input  logic                  RestoreValid,
    input  logic [DATA_WIDTH-1:0] RestoreData,
    output logic                  RestoreReady
);

    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_FETCH,
        SAVE_SEND,
        RESTORE,
        DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   idx_reg, idx_next;
    logic                    save_valid_reg, save_valid_next;
    logic [DATA_WIDTH-1:0]   save_data_reg, save_data_next;
    logic [ADDR_WIDTH-1:0]   save_index_reg, save_index_next;
    logic                    wr_en_reg, wr_en_next;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
    logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_reg      <= IDLE;
            idx_reg        <= FIRST_IDX;
            save_valid_reg <= 1'b0;
            save_data_reg  <= '0;
            save_index_reg <= '0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            save_valid_reg <= save_valid_next;
            save_data_reg  <= save_data_next;
            save_index_reg <= save_index_next;
            wr_en_reg      <= wr_en_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        save_valid_next = save_valid_reg;
        save_data_next  = save_data_reg;
        save_index_next = save_index_reg;
        // Write enable is a one-cycle strobe; it only rises after a restore handshake.
        wr_en_next      = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;

        case (state_reg)
            IDLE: begin
                idx_next = FIRST_IDX;
                if (SaveReq) begin
                    state_next = SAVE_FETCH;
                end else if (RestoreReq) begin
                    state_next = RESTORE;
                end
            end
            SAVE_FETCH: begin
                save_data_next  = RfReadData;
                save_index_next = idx_reg;
                save_valid_next = 1'b1;
                state_next      = SAVE_SEND;
            end
            SAVE_SEND: begin
                if (save_valid_reg && SaveReady) begin
                    save_valid_next = 1'b0;
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next   = idx_reg + ADDR_WIDTH'(1);
                        state_next = SAVE_FETCH;
                    end
                end
            end
            RESTORE: begin
                if (RestoreValid) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = idx_reg;
                    wr_data_next = RestoreData;
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + ADDR_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                idx_next   = FIRST_IDX;
                state_next = IDLE;
            end
            default: begin
                idx_next   = FIRST_IDX;
                state_next = IDLE;
            end
        endcase
    end

    assign Busy          = (state_reg != IDLE);
    assign Done          = (state_reg == DONE);
    assign RestoreReady  = (state_reg == RESTORE);
    assign RfReadAddr    = idx_reg;
    assign RfWriteAddr   = wr_addr_reg;
    assign RfWriteData   = wr_data_reg;
    assign RfWriteEnable = wr_en_reg;
    assign SaveValid     = save_valid_reg;
    assign SaveData      = save_data_reg;
    assign SaveIndex     = save_index_reg;

endmodule

// File: tb/tb_regfile_context_engine.sv
// Scoreboard bench: a register file model sits on the DUT ports; expected save beats,
// writes and Done pulses (with their cycle numbers) are queued and checked by a monitor.
module tb_regfile_context_engine;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          Clk = 1'b0;
    logic          ResetN = 1'b0;
    logic          SaveReq = 1'b0;
    logic          RestoreReq = 1'b0;
    logic          Busy;
    logic          Done;
    logic [AW-1:0] RfReadAddr;
    logic [DW-1:0] RfReadData;
    logic [AW-1:0] RfWriteAddr;
    logic [DW-1:0] RfWriteData;
    logic          RfWriteEnable;
    logic          SaveValid;
    logic [DW-1:0] SaveData;
    logic [AW-1:0] SaveIndex;
    logic          SaveReady = 1'b1;
    logic          RestoreValid = 1'b0;
    logic [DW-1:0] RestoreData;
    logic          RestoreReady;

    regfile_context_engine #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIRST_REG(0), .LAST_REG(31)
    ) dut (
        .Clk(Clk), .ResetN(ResetN), .SaveReq(SaveReq), .RestoreReq(RestoreReq),
        .Busy(Busy), .Done(Done), .RfReadAddr(RfReadAddr), .RfReadData(RfReadData),
        .RfWriteAddr(RfWriteAddr), .RfWriteData(RfWriteData), .RfWriteEnable(RfWriteEnable),
        .SaveValid(SaveValid), .SaveData(SaveData), .SaveIndex(SaveIndex), .SaveReady(SaveReady),
        .RestoreValid(RestoreValid), .RestoreData(RestoreData), .RestoreReady(RestoreReady)
    );

    always #5 Clk = ~Clk;

    // Register file model: combinational read, falling-edge write.
    logic [DW-1:0] rf [0:N-1];
    assign RfReadData = rf[RfReadAddr];
    always @(negedge Clk) if (RfWriteEnable) rf[RfWriteAddr] <= RfWriteData;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Restore source: beat counter advances on each handshake, cleared while idle.
    int            rbeat = 0;
    logic [DW-1:0] rbase = '0;
    always @(posedge Clk) begin
        if (!Busy) rbeat <= 0;
        else if (RestoreValid && RestoreReady) rbeat <= rbeat + 1;
    end
    assign RestoreData = rbase + DW'(rbeat);

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
        int            cyc;
    } beat_t;

    beat_t save_q[$];
    beat_t wr_q[$];
    int    done_q[$];
    int    checks = 0;
    int    errors = 0;

    always @(negedge Clk) begin
        if (SaveValid) begin
            checks++;
            if (save_q.size() == 0) begin
                errors++;
                $display("FAIL save_unexpected idx=%0d data=%h cyc=%0d", SaveIndex, SaveData, cyc);
            end else begin
                if (int'(SaveIndex) != save_q[0].idx || SaveData != save_q[0].data) begin
                    errors++;
                    $display("FAIL save_beat got idx=%0d data=%h want idx=%0d data=%h",
                             SaveIndex, SaveData, save_q[0].idx, save_q[0].data);
                end
                if (SaveReady) begin
                    checks++;
                    if (cyc != save_q[0].cyc) begin
                        errors++;
                        $display("FAIL save_cycle idx=%0d got cyc=%0d want cyc=%0d",
                                 SaveIndex, cyc, save_q[0].cyc);
                    end
                    $display("save  idx=%0d data=%h cyc=%0d", SaveIndex, SaveData, cyc);
                    void'(save_q.pop_front());
                end
            end
        end
        if (RfWriteEnable) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=%0d data=%h cyc=%0d", RfWriteAddr, RfWriteData, cyc);
            end else begin
                if (int'(RfWriteAddr) != wr_q[0].idx || RfWriteData != wr_q[0].data || cyc != wr_q[0].cyc) begin
                    errors++;
                    $display("FAIL write got addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             RfWriteAddr, RfWriteData, cyc, wr_q[0].idx, wr_q[0].data, wr_q[0].cyc);
                end
                $display("write addr=%0d data=%h cyc=%0d", RfWriteAddr, RfWriteData, cyc);
                void'(wr_q.pop_front());
            end
        end
        if (Done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected cyc=%0d", cyc);
            end else begin
                if (cyc != done_q[0]) begin
                    errors++;
                    $display("FAIL done_cycle got cyc=%0d want cyc=%0d", cyc, done_q[0]);
                end
                $display("done  cyc=%0d", cyc);
                void'(done_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        logic [3*DW+3*AW+5-1:0] v;
        v = {Busy, Done, SaveValid, RestoreReady, RfWriteEnable, SaveData, SaveIndex,
             RfWriteAddr, RfWriteData, RfReadAddr};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s outputs got=%h want=0", name, v);
        end
    endtask

    task automatic check_rf(input string name, input int i, input logic [DW-1:0] want);
        checks++;
        if (rf[i] !== want) begin
            errors++;
            $display("FAIL %s reg=%0d got=%h want=%h", name, i, rf[i], want);
        end
    endtask

    task automatic run_save(input logic [DW-1:0] base, input bit both, input bit pulse_restore,
                            input int stall_beat, input int stall_len);
        int c0;
        int t;
        int d;
        SaveReq = 1'b1;
        RestoreReq = both;
        tick();
        SaveReq = 1'b0;
        RestoreReq = 1'b0;
        c0 = cyc;
        check_bit("save_busy_rise", Busy, 1'b1);
        for (int k = 0; k < N; k++) begin
            d = (stall_beat >= 0 && k >= stall_beat) ? stall_len : 0;
            save_q.push_back('{k, base + DW'(k), c0 + 2 * k + 1 + d});
        end
        done_q.push_back(c0 + 2 * N + ((stall_beat >= 0) ? stall_len : 0));
        t = 0;
        while (Busy && t < 400) begin
            if (stall_beat >= 0 && cyc == c0 + 2 * stall_beat + 1) SaveReady = 1'b0;
            if (stall_beat >= 0 && cyc == c0 + 2 * stall_beat + 1 + stall_len) SaveReady = 1'b1;
            RestoreReq = (pulse_restore && cyc == c0 + 10);
            tick();
            t++;
        end
        RestoreReq = 1'b0;
        SaveReady = 1'b1;
        checks++;
        if (Busy) begin
            errors++;
            $display("FAIL save_timeout busy=%b", Busy);
        end
    endtask

    task automatic run_restore(input logic [DW-1:0] base, input int gap_at, input int gap_len,
                               input int reset_after);
        int c0;
        int t;
        int d;
        int nbeats;
        rbase = base;
        RestoreValid = 1'b1;
        RestoreReq = 1'b1;
        tick();
        RestoreReq = 1'b0;
        c0 = cyc;
        check_bit("restore_busy_rise", Busy, 1'b1);
        check_bit("restore_ready_rise", RestoreReady, 1'b1);
        nbeats = (reset_after > 0) ? reset_after : N;
        for (int k = 0; k < nbeats; k++) begin
            d = (gap_at >= 0 && k >= gap_at) ? gap_len : 0;
            wr_q.push_back('{k, base + DW'(k), c0 + k + 1 + d});
        end
        if (reset_after <= 0) done_q.push_back(c0 + N + ((gap_at >= 0) ? gap_len : 0));
        t = 0;
        while (Busy && t < 400) begin
            if (gap_at >= 0 && cyc == c0 + gap_at) RestoreValid = 1'b0;
            if (gap_at >= 0 && cyc == c0 + gap_at + gap_len) RestoreValid = 1'b1;
            if (reset_after > 0 && cyc == c0 + reset_after) begin
                @(negedge Clk);
                #1;
                ResetN = 1'b0;
                #1;
                check_bit("rst_mid_wren", RfWriteEnable, 1'b0);
                check_bit("rst_mid_ready", RestoreReady, 1'b0);
                check_bit("rst_mid_busy", Busy, 1'b0);
                check_bit("rst_mid_done", Done, 1'b0);
                RestoreValid = 1'b0;
                tick();
                tick();
                ResetN = 1'b1;
                tick();
                tick();
                break;
            end
            tick();
            t++;
        end
        RestoreValid = 1'b0;
        checks++;
        if (Busy) begin
            errors++;
            $display("FAIL restore_timeout busy=%b", Busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random inputs
        ResetN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            SaveReq      = 1'($urandom);
            RestoreReq   = 1'($urandom);
            SaveReady    = 1'($urandom);
            RestoreValid = 1'($urandom);
            rbase        = {$urandom, $urandom};
            tick();
            check_idle_outputs("reset_hold");
        end
        SaveReq = 1'b0;
        RestoreReq = 1'b0;
        SaveReady = 1'b1;
        RestoreValid = 1'b0;
        tick();
        ResetN = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset_release");

        // Full restore 0x1000+i, contiguous
        run_restore(64'h1000, -1, 0, 0);
        // Full save with an ignored RestoreReq pulse mid-operation
        run_save(64'h1000, 1'b0, 1'b1, -1, 0);
        for (int i = 0; i < N; i++) check_rf("save_rf_unchanged", i, 64'h1000 + DW'(i));
        check_bit("after_save_idle", Busy, 1'b0);
        // Save with 5 cycles of backpressure on beat 3
        run_save(64'h1000, 1'b0, 1'b0, 3, 5);
        // Restore 0xA000+i with a 3-cycle valid gap
        run_restore(64'hA000, 5, 3, 0);
        for (int i = 0; i < N; i++) check_rf("restore_rf", i, 64'hA000 + DW'(i));
        // Both requests together: save wins, readback of the restored data
        run_save(64'hA000, 1'b1, 1'b0, -1, 0);
        // Reset after 10 restore handshakes
        run_restore(64'hC000, -1, 0, 10);
        for (int i = 0; i < N; i++)
            check_rf("rst_mid_rf", i, (i < 10) ? 64'hC000 + DW'(i) : 64'hA000 + DW'(i));
        check_idle_outputs("after_mid_reset");

        repeat (3) tick();
        checks++;
        if (save_q.size() != 0 || wr_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL leftover save=%0d write=%0d done=%0d", save_q.size(), wr_q.size(), done_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
